// File: rtl/snn_pkg.sv
// Shared types and helpers for the spiking-neuron blocks.
// Holds the neuron FSM encoding and a width-generic saturating adder.
package snn_pkg;

    typedef enum logic [1:0] {
        ST_INTEGRATE  = 2'd0,
        ST_FIRE       = 2'd1,
        ST_REFRACTORY = 2'd2
    } neuron_state_t;

    // Adds two signed values and clamps the result to a signed range of 'width' bits.
    function automatic longint sat_add(input longint a, input longint b, input int width);
        longint max_v;
        longint min_v;
        longint s;
        max_v = (longint'(1) <<< (width - 1)) - 1;
        min_v = -(longint'(1) <<< (width - 1));
        s = a + b;
        if (s > max_v)
            return max_v;
        if (s < min_v)
            return min_v;
        return s;
    endfunction

endpackage

// File: rtl/synapse_sum.sv
// Combinational weighted sum of the active synapses.
// The output is wide enough that adding every weight at full magnitude cannot overflow.
module synapse_sum #(
    parameter int NUM_INPUTS = 4,
    parameter int WEIGHT_W   = 8
) (
    input  logic [NUM_INPUTS-1:0]                spike_in,
    input  logic [NUM_INPUTS*WEIGHT_W-1:0]       weights,
    output logic [WEIGHT_W+$clog2(NUM_INPUTS):0] sum
);

    localparam int SUM_W = WEIGHT_W + $clog2(NUM_INPUTS) + 1;

    always_comb begin
        sum = '0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            if (spike_in[i])
                sum = sum + SUM_W'($signed(weights[i*WEIGHT_W +: WEIGHT_W]));
        end
    end

endmodule

// File: rtl/if_neuron.sv
// Integrate-and-fire neuron: accumulates weighted input spikes into a saturating
// membrane potential, fires one pulse on threshold, then sits out a refractory period.
module if_neuron
    import snn_pkg::*;
#(
    parameter int NUM_INPUTS = 4,
    parameter int WEIGHT_W   = 8,
    parameter int VMEM_W     = 16,
    parameter int THRESH     = 64,
    parameter int REFRAC     = 5
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_INPUTS-1:0]          spike_in,
    input  logic [NUM_INPUTS*WEIGHT_W-1:0] weights,
    input  logic                           neuron_rst,
    output logic                           spike_out,
    output logic [VMEM_W-1:0]              vmem,
    output logic                           refrac
);

    localparam int SUM_W = WEIGHT_W + $clog2(NUM_INPUTS) + 1;
    // A zero-length refractory still needs a legal one-bit counter.
    localparam int CNT_W = (REFRAC > 0) ? $clog2(REFRAC + 1) : 1;
    localparam logic signed [VMEM_W-1:0] THRESH_V = VMEM_W'(THRESH);

    logic signed [SUM_W-1:0]  syn_sum;
    logic signed [VMEM_W-1:0] vmem_q;
    logic signed [VMEM_W-1:0] vmem_next;
    logic signed [VMEM_W-1:0] vmem_sat;
    logic [CNT_W-1:0]         cnt_q;
    logic [CNT_W-1:0]         cnt_next;
    neuron_state_t            state;
    neuron_state_t            state_next;

    synapse_sum #(
        .NUM_INPUTS (NUM_INPUTS),
        .WEIGHT_W   (WEIGHT_W)
    ) u_synapse_sum (
        .spike_in (spike_in),
        .weights  (weights),
        .sum      (syn_sum)
    );

    assign vmem_sat = VMEM_W'(sat_add(longint'(vmem_q), longint'(syn_sum), VMEM_W));

    always_comb begin
        state_next = state;
        vmem_next  = vmem_q;
        cnt_next   = cnt_q;
        case (state)
            ST_INTEGRATE: begin
                // The layer clear wins over both integration and a threshold crossing.
                if (neuron_rst) begin
                    vmem_next = '0;
                end else if (vmem_sat >= THRESH_V) begin
                    state_next = ST_FIRE;
                    vmem_next  = '0;
                end else begin
                    vmem_next = vmem_sat;
                end
            end
            ST_FIRE: begin
                vmem_next = '0;
                if (REFRAC > 0) begin
                    state_next = ST_REFRACTORY;
                    cnt_next   = CNT_W'(REFRAC);
                end else begin
                    state_next = ST_INTEGRATE;
                end
            end
            ST_REFRACTORY: begin
                vmem_next = '0;
                if (cnt_q <= CNT_W'(1)) begin
                    state_next = ST_INTEGRATE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_q - 1'b1;
                end
            end
            default: begin
                state_next = ST_INTEGRATE;
                vmem_next  = '0;
                cnt_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= ST_INTEGRATE;
            vmem_q <= '0;
            cnt_q  <= '0;
        end else begin
            state  <= state_next;
            vmem_q <= vmem_next;
            cnt_q  <= cnt_next;
        end
    end

    assign vmem      = vmem_q;
    assign spike_out = (state == ST_FIRE);
    assign refrac    = (state != ST_INTEGRATE);

endmodule

// File: tb/tb_if_neuron.sv
// Testbench for if_neuron: directed scenarios plus randomized traffic, all checked
// against an abstract neuron model (potential + remaining busy cycles).
module tb_if_neuron;

    localparam int NI = 4;
    localparam int WW = 8;
    localparam int VW = 16;
    localparam int TH = 64;
    localparam int RF = 5;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  spike_in;
    logic [31:0] weights;
    logic        neuron_rst;
    logic        spike_out;
    logic [15:0] vmem;
    logic        refrac;

    logic [3:0]  spike_in0;
    logic [31:0] weights0;
    logic        neuron_rst0;
    logic        spike_out0;
    logic [15:0] vmem0;
    logic        refrac0;

    int vectors     = 0;
    int miscompares = 0;
    int m_vm        = 0;
    int m_busy      = 0;

    always #5 clk = ~clk;

    if_neuron #(.NUM_INPUTS(NI), .WEIGHT_W(WW), .VMEM_W(VW), .THRESH(TH), .REFRAC(RF)) dut (
        .clk        (clk),
        .rst        (rst),
        .spike_in   (spike_in),
        .weights    (weights),
        .neuron_rst (neuron_rst),
        .spike_out  (spike_out),
        .vmem       (vmem),
        .refrac     (refrac)
    );

    if_neuron #(.NUM_INPUTS(NI), .WEIGHT_W(WW), .VMEM_W(VW), .THRESH(TH), .REFRAC(0)) dut0 (
        .clk        (clk),
        .rst        (rst),
        .spike_in   (spike_in0),
        .weights    (weights0),
        .neuron_rst (neuron_rst0),
        .spike_out  (spike_out0),
        .vmem       (vmem0),
        .refrac     (refrac0)
    );

    function automatic int syn_total(input logic [3:0] s, input logic [31:0] w);
        int t = 0;
        for (int i = 0; i < NI; i++)
            if (s[i]) t += int'($signed(w[i*WW +: WW]));
        return t;
    endfunction

    // Reference: after a crossing the neuron is busy for RF+1 cycles (fire + refractory).
    task automatic apply_stimulus(input logic [3:0] s, input logic [31:0] w, input logic nr);
        int nv;
        spike_in   = s;
        weights    = w;
        neuron_rst = nr;
        @(posedge clk);
        if (m_busy > 0) begin
            m_busy--;
            m_vm = 0;
        end else if (nr) begin
            m_vm = 0;
        end else begin
            nv = m_vm + syn_total(s, w);
            if (nv > 32767)  nv = 32767;
            if (nv < -32768) nv = -32768;
            if (nv >= TH) begin
                m_vm   = 0;
                m_busy = RF + 1;
            end else begin
                m_vm = nv;
            end
        end
        #1;
    endtask

    task automatic test_reset;
        rst         = 1'b0;
        spike_in    = '0;
        weights     = '0;
        neuron_rst  = 1'b0;
        spike_in0   = '0;
        weights0    = '0;
        neuron_rst0 = 1'b0;
        #1;
        vectors++;
        if (vmem !== 16'd0 || spike_out !== 1'b0 || refrac !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset: vmem=%0d spike=%b refrac=%b, expected 0 0 0", $signed(vmem), spike_out, refrac);
        end
        vectors++;
        if (vmem0 !== 16'd0 || spike_out0 !== 1'b0 || refrac0 !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_r0: vmem=%0d spike=%b refrac=%b, expected 0 0 0", $signed(vmem0), spike_out0, refrac0);
        end
        @(posedge clk);
        @(posedge clk);
        #2;
        rst    = 1'b1;
        m_vm   = 0;
        m_busy = 0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_fire_sequence;
        int  exp_vm[12] = '{20, 40, 60, 0, 0, 0, 0, 0, 0, 0, 20, 40};
        bit  exp_sp[12] = '{0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0};
        bit  exp_rf[12] = '{0, 0, 0, 1, 1, 1, 1, 1, 1, 0, 0, 0};
        for (int k = 0; k < 12; k++) begin
            apply_stimulus(4'b0001, 32'h14141414, 1'b0);
            vectors++;
            if (vmem !== 16'(exp_vm[k]) || spike_out !== exp_sp[k] || refrac !== exp_rf[k]) begin
                miscompares++;
                $display("[TB] FAIL fire_seq[%0d]: vmem=%0d spike=%b refrac=%b, expected vmem=%0d spike=%b refrac=%b",
                         k, $signed(vmem), spike_out, refrac, exp_vm[k], exp_sp[k], exp_rf[k]);
            end
        end
    endtask

    task automatic test_negative_saturation;
        apply_stimulus(4'b0000, 32'h0, 1'b1);
        for (int k = 1; k <= 5; k++) begin
            apply_stimulus(4'b1111, 32'h1E1E1E9C, 1'b0);
            vectors++;
            if ($signed(vmem) !== 16'(-10 * k) || refrac !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL neg_step[%0d]: vmem=%0d refrac=%b, expected vmem=%0d refrac=0", k, $signed(vmem), refrac, -10 * k);
            end
        end
        for (int k = 0; k < 70; k++) begin
            apply_stimulus(4'b1111, 32'h80808080, 1'b0);
            vectors++;
            if (vmem !== 16'(m_vm) || spike_out !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL neg_sat[%0d]: vmem=%0d spike=%b, expected vmem=%0d spike=0", k, $signed(vmem), spike_out, m_vm);
            end
        end
        vectors++;
        if (vmem !== 16'h8000) begin
            miscompares++;
            $display("[TB] FAIL neg_floor: vmem=%0d, expected -32768", $signed(vmem));
        end
        for (int k = 0; k < 3; k++) begin
            apply_stimulus(4'b0000, 32'h64646464, 1'b0);
            vectors++;
            if (vmem !== 16'h8000) begin
                miscompares++;
                $display("[TB] FAIL idle_hold[%0d]: vmem=%0d, expected -32768", k, $signed(vmem));
            end
        end
        apply_stimulus(4'b0000, 32'h0, 1'b1);
    endtask

    task automatic test_nrst_crossing;
        for (int k = 0; k < 3; k++)
            apply_stimulus(4'b0001, 32'h00000014, 1'b0);
        vectors++;
        if (vmem !== 16'd60) begin
            miscompares++;
            $display("[TB] FAIL nrst_pre: vmem=%0d, expected 60", $signed(vmem));
        end
        apply_stimulus(4'b0001, 32'h0000000A, 1'b1);
        vectors++;
        if (vmem !== 16'd0 || spike_out !== 1'b0 || refrac !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL nrst_cross: vmem=%0d spike=%b refrac=%b, expected 0 0 0", $signed(vmem), spike_out, refrac);
        end
        apply_stimulus(4'b0000, 32'h0, 1'b0);
        vectors++;
        if (vmem !== 16'd0 || spike_out !== 1'b0 || refrac !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL nrst_after: vmem=%0d spike=%b refrac=%b, expected 0 0 0", $signed(vmem), spike_out, refrac);
        end
    endtask

    task automatic test_nrst_in_refrac;
        bit exp_rf[8] = '{1, 1, 1, 1, 1, 1, 0, 1};
        bit exp_sp[8] = '{1, 0, 0, 0, 0, 0, 0, 1};
        for (int k = 0; k < 8; k++) begin
            apply_stimulus(4'b0001, 32'h00000064, (k == 2 || k == 4));
            vectors++;
            if (vmem !== 16'd0 || spike_out !== exp_sp[k] || refrac !== exp_rf[k]) begin
                miscompares++;
                $display("[TB] FAIL nrst_refrac[%0d]: vmem=%0d spike=%b refrac=%b, expected vmem=0 spike=%b refrac=%b",
                         k, $signed(vmem), spike_out, refrac, exp_sp[k], exp_rf[k]);
            end
        end
        for (int k = 0; k < 6; k++)
            apply_stimulus(4'b0000, 32'h0, 1'b0);
    endtask

    task automatic test_reset_mid_refrac;
        apply_stimulus(4'b0001, 32'h00000064, 1'b0);
        apply_stimulus(4'b0001, 32'h00000064, 1'b0);
        apply_stimulus(4'b0001, 32'h00000064, 1'b0);
        vectors++;
        if (refrac !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL pre_abort: refrac=%b, expected 1", refrac);
        end
        rst = 1'b0;
        #1;
        vectors++;
        if (vmem !== 16'd0 || spike_out !== 1'b0 || refrac !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL async_abort: vmem=%0d spike=%b refrac=%b, expected 0 0 0", $signed(vmem), spike_out, refrac);
        end
        #1;
        rst    = 1'b1;
        m_vm   = 0;
        m_busy = 0;
        apply_stimulus(4'b0001, 32'h14141414, 1'b0);
        vectors++;
        if (vmem !== 16'd20 || spike_out !== 1'b0 || refrac !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL post_abort: vmem=%0d spike=%b refrac=%b, expected 20 0 0", $signed(vmem), spike_out, refrac);
        end
        apply_stimulus(4'b0000, 32'h0, 1'b1);
    endtask

    task automatic test_random;
        logic [31:0] w;
        logic [3:0]  s;
        logic        nr;
        w = '0;
        for (int k = 0; k < 400; k++) begin
            if (k % 25 == 0) begin
                for (int i = 0; i < NI; i++)
                    w[i*WW +: WW] = (k % 100 == 50) ? 8'($urandom_range(0, 255)) : 8'(int'($urandom_range(0, 90)) - 30);
            end
            s  = 4'($urandom_range(0, 15));
            nr = ($urandom_range(0, 15) == 0);
            apply_stimulus(s, w, nr);
            vectors++;
            if (vmem !== 16'(m_vm) || spike_out !== (m_busy == RF + 1) || refrac !== (m_busy > 0)) begin
                miscompares++;
                $display("[TB] FAIL random[%0d]: vmem=%0d spike=%b refrac=%b, expected vmem=%0d spike=%b refrac=%b",
                         k, $signed(vmem), spike_out, refrac, m_vm, (m_busy == RF + 1), (m_busy > 0));
            end
        end
    endtask

    task automatic test_refrac_zero;
        spike_in0   = 4'b0001;
        weights0    = 32'h00000064;
        neuron_rst0 = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk);
            #1;
            vectors++;
            if (spike_out0 !== 1'(k % 2) || refrac0 !== 1'(k % 2) || vmem0 !== 16'd0) begin
                miscompares++;
                $display("[TB] FAIL refrac0[%0d]: spike=%b refrac=%b vmem=%0d, expected spike=%0d refrac=%0d vmem=0",
                         k, spike_out0, refrac0, $signed(vmem0), k % 2, k % 2);
            end
        end
        spike_in0 = '0;
    endtask

    initial begin
        test_reset;
        test_fire_sequence;
        test_negative_saturation;
        test_nrst_crossing;
        test_nrst_in_refrac;
        test_reset_mid_refrac;
        test_random;
        test_refrac_zero;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
